// File: rtl/exp_pkg.sv
// exp_pkg: shared definitions for the log2 -> linear conversion block.
//   Q_L / Q_O / MQ : fractional bits of the input, the output and the mantissa
//   state_t        : controller states IDLE -> MUL -> SCALE
//   exp_coef()     : Q30 constants C[i] = round(2^(2^-(i+1)) * 2^30), i = 0..Q_L-1
package exp_pkg;

  localparam int Q_L = 11;
  localparam int Q_O = 16;
  localparam int MQ  = 30;
  localparam int D_W = 16;
  localparam int K_W = D_W - Q_L;

  localparam logic [31:0] MANT_ONE = 32'h4000_0000;  // 1.0 in Q30
  localparam logic [31:0] SAT_MAX  = 32'h7FFF_FFFF;
  localparam logic [3:0]  CNT_LAST = 4'(Q_L - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    SCALE = 2'd2
  } state_t;

  // 2^(1/2), 2^(1/4), ... 2^(1/2048) in Q30, one per fractional input bit,
  // most significant fraction bit first.
  function automatic logic [31:0] exp_coef(input logic [3:0] idx);
    logic [31:0] c;
    case (idx)
      4'd0:    c = 32'h5A82_799A;
      4'd1:    c = 32'h4C1B_F829;
      4'd2:    c = 32'h45CA_E0F2;
      4'd3:    c = 32'h42D5_61B4;
      4'd4:    c = 32'h4166_C34C;
      4'd5:    c = 32'h40B2_68FA;
      4'd6:    c = 32'h4058_F6A8;
      4'd7:    c = 32'h402C_6BE9;
      4'd8:    c = 32'h4016_321B;
      4'd9:    c = 32'h400B_1818;
      4'd10:   c = 32'h4005_8BCE;
      default: c = MANT_ONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exp_module.sv
// exp_module: converts a signed Q11 log2 value to a linear Q16 value, y = 2^x.
//   The fraction f is resolved by Q_L sequential constant multiplies on a Q30
//   mantissa (one shared 32x32 multiplier), then the integer part k scales the
//   mantissa by a barrel shift of s = MQ - Q_O - k with saturation.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   data_in     in   [15:0] signed log2 value, Q11
//   data_valid  in   input qualifier
//   in_ready    out  high in IDLE
//   exp_out     out  [31:0] linear result, Q16, held until the next result
//   exp_valid   out  one-cycle pulse with exp_out
//   o_dbg_state out  [1:0] current controller state (state_t encoding)
// Build option: define EXP_ROUND_EN for round-half-up on every multiply and
//   on the final right shift; otherwise both truncate. Latency is identical.
module exp_module
  import exp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        in_ready,
  output logic [31:0] exp_out,
  output logic        exp_valid,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a sample is taken on a rising edge where data_valid and
  // in_ready are both high. in_ready is high only in IDLE; data_valid at any
  // other time is ignored, nothing is queued. exp_valid is a single-cycle
  // pulse with no back-pressure, exp_out stays stable afterwards.

`ifdef EXP_ROUND_EN
  localparam logic [63:0] MUL_RND = 64'd1 << (MQ - 1);
`else
  localparam logic [63:0] MUL_RND = 64'd0;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [K_W-1:0]   r_k;
  logic [Q_L-1:0]   r_f;
  logic [31:0]      r_mant;
  logic [3:0]       r_cnt;
  logic [31:0]      r_exp_out;
  logic             r_exp_valid;

  logic             w_accept;
  logic [31:0]      w_coef;
  logic [31:0]      w_mant_mul;
  logic [7:0]       w_s;
  logic [7:0]       w_s_neg;
  logic [63:0]      w_wide;
  logic [31:0]      w_scale_res;

  assign w_accept    = data_valid & in_ready;
  assign exp_out     = r_exp_out;
  assign exp_valid   = r_exp_valid;
  assign o_dbg_state = r_state;

  // Mantissa stays below 2^31, so the Q60 product fits in 62 bits and the
  // Q30 result fits back into 32 bits.
  assign w_coef     = exp_coef(r_cnt);
  assign w_mant_mul = 32'((({32'd0, r_mant} * {32'd0, w_coef}) + MUL_RND) >> MQ);

  // Scale by 2^k: s = MQ - Q_O - k, negative s means a left shift.
  always_comb begin
    w_s         = 8'(MQ - Q_O) - {{(8 - K_W){r_k[K_W-1]}}, r_k};
    w_s_neg     = 8'd0 - w_s;
    w_wide      = '0;
    w_scale_res = '0;
    if (w_s[7]) begin
      w_wide = {32'd0, r_mant} << w_s_neg;
      if ((w_s_neg > 8'd32 && r_mant != '0) || w_wide > 64'h0000_0000_7FFF_FFFF)
        w_scale_res = SAT_MAX;
      else
        w_scale_res = w_wide[31:0];
    end else if (w_s >= 8'd32) begin
      w_scale_res = '0;
    end else begin
`ifdef EXP_ROUND_EN
      if (w_s != 8'd0)
        w_wide = ({32'd0, r_mant} + (64'd1 << (w_s - 8'd1))) >> w_s;
      else
        w_wide = {32'd0, r_mant};
`else
      w_wide = {32'd0, r_mant} >> w_s;
`endif
      if (w_wide > 64'h0000_0000_7FFF_FFFF)
        w_scale_res = SAT_MAX;
      else
        w_scale_res = w_wide[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (data_valid) w_state_nxt = MUL;
      end
      MUL: begin
        if (r_cnt == CNT_LAST) w_state_nxt = SCALE;
      end
      SCALE: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // f is shifted left each MUL cycle so its MSB always selects C[cnt];
  // the multiply slot is spent every cycle to keep latency independent of f.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k         <= '0;
      r_f         <= '0;
      r_mant      <= MANT_ONE;
      r_cnt       <= '0;
      r_exp_out   <= '0;
      r_exp_valid <= 1'b0;
    end else begin
      r_exp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_k    <= data_in[D_W-1:Q_L];
            r_f    <= data_in[Q_L-1:0];
            r_mant <= MANT_ONE;
            r_cnt  <= '0;
          end
        end
        MUL: begin
          if (r_f[Q_L-1]) r_mant <= w_mant_mul;
          r_f   <= {r_f[Q_L-2:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
        end
        SCALE: begin
          r_exp_out   <= w_scale_res;
          r_exp_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_module.sv
// tb_exp_module: randomized and directed bench for exp_module with a
// scoreboard queue filled by the drivers and drained by a monitor.
module tb_exp_module;
  import exp_pkg::*;

  localparam int LAT    = 12;  // accept edge to the edge raising exp_valid
  localparam int PERIOD = 13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        in_ready;
  logic [31:0] exp_out;
  logic        exp_valid;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  int          acc_q[$];
  logic [63:0] c_tab[11];
  logic [31:0] mon_e;
  int          mon_a;

  exp_module dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .in_ready    (in_ready),
    .exp_out     (exp_out),
    .exp_valid   (exp_valid),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_exp(input logic [15:0] x);
    int xs, k, f, s;
    logic [63:0] m, r;
    xs = int'($signed(x));
    k  = (xs >= 0) ? (xs / 2048) : -((-xs + 2047) / 2048);
    f  = xs - k * 2048;
    m  = 64'd1 << 30;
    for (int i = 0; i < 11; i++) begin
      if (((f >> (10 - i)) & 1) == 1) begin
        m = m * c_tab[i];
`ifdef EXP_ROUND_EN
        m = m + (64'd1 << 29);
`endif
        m = m >> 30;
      end
    end
    s = 30 - 16 - k;
    if (s < 0)        r = m << (-s);
    else if (s >= 32) r = 64'd0;
    else begin
`ifdef EXP_ROUND_EN
      r = (s >= 1) ? ((m + (64'd1 << (s - 1))) >> s) : m;
`else
      r = m >> s;
`endif
    end
    if (r > 64'h7FFF_FFFF) r = 64'h7FFF_FFFF;
    return r[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%08h) required=%0d (0x%08h) t=%0t", name, act, act, req, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && exp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=0x%08h required=no_output t=%0t", exp_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = acc_q.pop_front();
        check("exp_out", exp_out, mon_e);
        check("latency", 32'(cyc - mon_a), 32'(LAT));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  task automatic send(input logic [15:0] x, input logic [31:0] e, input bit track);
    wait_ready();
    data_in    = x;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    if (track) begin
      exp_q.push_back(e);
      acc_q.push_back(cyc);
    end
    data_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] d_in[6];
  logic [31:0] d_exp[6];
  logic [15:0] edge_vals[6];

  initial begin
    int n_acc;
    int last_acc;
    bit was_ready;
    logic [15:0] x;

    for (int i = 0; i < 11; i++)
      c_tab[i] = 64'($rtoi((2.0 ** (1.0 / (2.0 ** (i + 1)))) * 1073741824.0 + 0.5));

    d_in[0] = 16'h0000; d_exp[0] = 32'd65536;
    d_in[1] = 16'h0800; d_exp[1] = 32'd131072;
    d_in[2] = 16'hF800; d_exp[2] = 32'd32768;
`ifdef EXP_ROUND_EN
    d_in[3] = 16'h0400; d_exp[3] = 32'd92682;
`else
    d_in[3] = 16'h0400; d_exp[3] = 32'd92681;
`endif
    d_in[4] = 16'h7FFF; d_exp[4] = 32'h7FFF_FFFF;
    d_in[5] = 16'h8000; d_exp[5] = 32'd1;

    edge_vals[0] = 16'h7FFF; edge_vals[1] = 16'h8000; edge_vals[2] = 16'h77FF;
    edge_vals[3] = 16'h7800; edge_vals[4] = 16'h87FF; edge_vals[5] = 16'hFFFF;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_exp_out", exp_out, 32'd0);
    check("rst_exp_valid", 32'(exp_valid), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'(IDLE));
    rst = 1'b0;

    // directed values, back to back
    for (int i = 0; i < 6; i++) send(d_in[i], d_exp[i], 1'b1);
    drain();
    repeat (5) @(negedge clk);
    check("exp_out_hold", exp_out, 32'd1);

    // reset in MUL cycle 5 aborts the sample
    send(16'h1234, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_exp_out", exp_out, 32'd0);
    check("abort_exp_valid", 32'(exp_valid), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send(16'h0800, 32'd131072, 1'b1);
    drain();

    // randomized samples with random idle gaps, boundary values mixed in
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) x = edge_vals[$urandom_range(0, 5)];
      else                           x = 16'($urandom_range(0, 65535));
      send(x, model_exp(x), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // data_valid held high: accepts only when ready, one per PERIOD cycles
    n_acc    = 0;
    last_acc = -1;
    for (int t = 0; t < 6 * PERIOD; t++) begin
      @(negedge clk);
      data_in    = 16'($urandom_range(0, 65535));
      data_valid = 1'b1;
      was_ready  = in_ready;
      @(posedge clk);
      #1;
      if (was_ready) begin
        exp_q.push_back(model_exp(data_in));
        acc_q.push_back(cyc);
        if (last_acc >= 0) check("stream_spacing", 32'(cyc - last_acc), 32'(PERIOD));
        last_acc = cyc;
        n_acc++;
      end
    end
    data_valid = 1'b0;
    check("stream_accepts", 32'(n_acc), 32'd6);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
